// File: rtl/space_invaders_pkg.sv
// Shared geometry, coordinate type and player state encoding for the invaders game.
// No logic here: constants and types only, so there is no latency and no backpressure.
package space_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int PLAYER_W = 26;
  localparam int PLAYER_Y = 440;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [1:0]         pstate_t;

  localparam pstate_t ST_ALIVE     = 2'd0;
  localparam pstate_t ST_DEAD      = 2'd1;
  localparam pstate_t ST_GAME_OVER = 2'd2;

  typedef struct packed {
    logic   active;
    coord_t x;
    coord_t y;
  } bullet_t;

  function automatic coord_t centre_x();
    return coord_t'((SCREEN_W - PLAYER_W) / 2);
  endfunction

endpackage

// File: rtl/player_control_if.sv
// Bundles the button/hit inputs and the player state outputs of player_control.
// Pure wiring: no latency; strobes and levels only, so there is no backpressure.
interface player_control_if;
  import space_invaders_pkg::*;

  logic       tick;
  logic       left;
  logic       right;
  logic       shoot;
  logic       soft_rst;
  logic       bullet_hit;
  logic       player_hit;

  coord_t     player_x;
  logic       player_alive;
  logic       bullet_active;
  coord_t     bullet_x;
  coord_t     bullet_y;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output tick, left, right, shoot, soft_rst, bullet_hit, player_hit,
    input  player_x, player_alive, bullet_active, bullet_x, bullet_y, lives, game_over
  );

  modport slave (
    input  tick, left, right, shoot, soft_rst, bullet_hit, player_hit,
    output player_x, player_alive, bullet_active, bullet_x, bullet_y, lives, game_over
  );

endinterface

// File: rtl/player_bullet.sv
// Single player bullet: launch from the cannon, rise per tick, clear on hit or off the top.
// One clock from strobe to state; no backpressure, requests not taken on a tick are lost upstream.
module player_bullet
  import space_invaders_pkg::*;
#(
  parameter int BULLET_H    = 8,
  parameter int BULLET_STEP = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  logic    kill,
  input  logic    hit,
  input  logic    advance,
  input  logic    fire,
  input  coord_t  player_x,
  output bullet_t bullet
);

  localparam coord_t LAUNCH_DX = coord_t'(PLAYER_W / 2);
  localparam coord_t LAUNCH_Y  = coord_t'(PLAYER_Y - BULLET_H);
  localparam coord_t STEP      = coord_t'(BULLET_STEP);

  // A hit on an idle bullet must not swallow a launch in the same cycle.
  logic clear_now;
  assign clear_now = kill || (hit && bullet.active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bullet <= '0;
    end else if (clr) begin
      bullet <= '0;
    end else if (clear_now) begin
      bullet.active <= 1'b0;
    end else if (advance) begin
      if (!bullet.active) begin
        if (fire) begin
          bullet.active <= 1'b1;
          bullet.x      <= player_x + LAUNCH_DX;
          bullet.y      <= LAUNCH_Y;
        end
      end else if (bullet.y < STEP) begin
        bullet.active <= 1'b0;
      end else begin
        bullet.y <= bullet.y - STEP;
      end
    end
  end

endmodule

// File: rtl/player_control.sv
// Cannon position, lives and respawn/game-over FSM; owns the player bullet sub-block.
// One clock from input to outputs; no backpressure, shoot requests expire at the next tick.
module player_control
  import space_invaders_pkg::*;
#(
  parameter int PLAYER_STEP   = 2,
  parameter int BULLET_H      = 8,
  parameter int BULLET_STEP   = 4,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 60
) (
  input logic             clk,
  input logic             rst_n,
  player_control_if.slave bus
);

  localparam coord_t     X_MAX        = coord_t'(SCREEN_W - PLAYER_W);
  localparam coord_t     X_HI         = coord_t'(SCREEN_W - PLAYER_W - PLAYER_STEP);
  localparam coord_t     STEP         = coord_t'(PLAYER_STEP);
  localparam logic [2:0] LIVES_INIT   = 3'(LIVES);
  localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_TICKS - 1);

  pstate_t    state;
  coord_t     player_x;
  coord_t     x_next;
  logic [2:0] lives;
  logic [7:0] timer;
  logic       shoot_d;
  logic       shoot_req;
  logic       alive;
  logic       hit_alive;
  bullet_t    bullet;

  assign alive     = (state == ST_ALIVE);
  assign hit_alive = alive && bus.player_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shoot_d   <= 1'b0;
      shoot_req <= 1'b0;
    end else begin
      shoot_d <= bus.shoot;
      if (bus.soft_rst || bus.tick) begin
        shoot_req <= 1'b0;
      end else if (bus.shoot && !shoot_d) begin
        shoot_req <= 1'b1;
      end
    end
  end

  // Clamp checks come before the arithmetic so the 10-bit position never wraps.
  always_comb begin
    x_next = player_x;
    if (bus.left && !bus.right) begin
      x_next = (player_x < STEP) ? '0 : player_x - STEP;
    end else if (bus.right && !bus.left) begin
      x_next = (player_x > X_HI) ? X_MAX : player_x + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ALIVE;
      player_x <= centre_x();
      lives    <= LIVES_INIT;
      timer    <= '0;
    end else if (bus.soft_rst) begin
      state    <= ST_ALIVE;
      player_x <= centre_x();
      lives    <= LIVES_INIT;
      timer    <= '0;
    end else begin
      case (state)
        ST_ALIVE: begin
          if (bus.player_hit) begin
            lives <= lives - 3'd1;
            timer <= RESPAWN_LOAD;
            state <= (lives == 3'd1) ? ST_GAME_OVER : ST_DEAD;
          end else if (bus.tick) begin
            player_x <= x_next;
          end
        end
        ST_DEAD: begin
          if (bus.tick) begin
            if (timer == 8'd0) begin
              state    <= ST_ALIVE;
              player_x <= centre_x();
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  player_bullet #(
    .BULLET_H    (BULLET_H),
    .BULLET_STEP (BULLET_STEP)
  ) u_bullet (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.soft_rst),
    .kill     (hit_alive),
    .hit      (bus.bullet_hit),
    .advance  (bus.tick && alive),
    .fire     (shoot_req),
    .player_x (player_x),
    .bullet   (bullet)
  );

  assign bus.player_x      = player_x;
  assign bus.player_alive  = alive;
  assign bus.bullet_active = bullet.active;
  assign bus.bullet_x      = bullet.x;
  assign bus.bullet_y      = bullet.y;
  assign bus.lives         = lives;
  assign bus.game_over     = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_player_control.sv
// Directed bench for player_control: movement clamps, bullet flight, hits, respawn, game over, async reset.
module tb_player_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  player_control_if pc_if ();

  player_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pc_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pc_if.tick = 1'b1;
      @(negedge clk);
      pc_if.tick = 1'b0;
    end
  endtask

  task automatic shoot_pulse();
    pc_if.shoot = 1'b1;
    @(negedge clk);
    pc_if.shoot = 1'b0;
    @(negedge clk);
  endtask

  task automatic phit();
    pc_if.player_hit = 1'b1;
    @(negedge clk);
    pc_if.player_hit = 1'b0;
  endtask

  task automatic soft_restart();
    pc_if.soft_rst = 1'b1;
    @(negedge clk);
    pc_if.soft_rst = 1'b0;
  endtask

  initial begin
    pc_if.tick = 0; pc_if.left = 0; pc_if.right = 0; pc_if.shoot = 0;
    pc_if.soft_rst = 0; pc_if.bullet_hit = 0; pc_if.player_hit = 0;
    repeat (2) @(negedge clk);
    chk("rst_x", pc_if.player_x, 307);
    chk("rst_alive", pc_if.player_alive, 1);
    chk("rst_lives", pc_if.lives, 3);
    chk("rst_go", pc_if.game_over, 0);
    chk("rst_bact", pc_if.bullet_active, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Right to the clamp, both held, then left back down to 0.
    pc_if.right = 1;
    ticks(1);   chk("right_1", pc_if.player_x, 309);
    ticks(152); chk("right_153", pc_if.player_x, 613);
    ticks(1);   chk("right_clamp", pc_if.player_x, 614);
    ticks(46);  chk("right_200", pc_if.player_x, 614);
    pc_if.left = 1;
    ticks(3);   chk("both_hold", pc_if.player_x, 614);
    pc_if.right = 0;
    ticks(1);   chk("left_1", pc_if.player_x, 612);
    ticks(306); chk("left_near0", pc_if.player_x, 0);
    pc_if.left = 0;
    soft_restart();
    chk("soft_x", pc_if.player_x, 307);

    // Bullet launch and full flight.
    shoot_pulse();
    ticks(1);
    chk("launch_act", pc_if.bullet_active, 1);
    chk("launch_x", pc_if.bullet_x, 320);
    chk("launch_y", pc_if.bullet_y, 432);
    ticks(108);
    chk("top_y", pc_if.bullet_y, 0);
    chk("top_act", pc_if.bullet_active, 1);
    ticks(1);
    chk("off_top", pc_if.bullet_active, 0);

    // Launch uses pre-move X.
    pc_if.right = 1;
    shoot_pulse();
    ticks(1);
    pc_if.right = 0;
    chk("premove_bx", pc_if.bullet_x, 320);
    chk("premove_px", pc_if.player_x, 309);
    chk("premove_by", pc_if.bullet_y, 432);

    // Shoot while active: no relaunch, request dropped.
    pc_if.shoot = 1;
    @(negedge clk);
    ticks(1);
    pc_if.shoot = 0;
    chk("norelaunch_y", pc_if.bullet_y, 428);
    chk("norelaunch_x", pc_if.bullet_x, 320);
    pc_if.bullet_hit = 1; pc_if.tick = 1;
    @(negedge clk);
    pc_if.bullet_hit = 0; pc_if.tick = 0;
    chk("bhit_act", pc_if.bullet_active, 0);
    chk("bhit_y", pc_if.bullet_y, 428);
    ticks(1);
    chk("dropped_req", pc_if.bullet_active, 0);

    // Player hit coincident with tick while moving: hit wins.
    shoot_pulse();
    ticks(1);
    chk("relaunch", pc_if.bullet_active, 1);
    pc_if.left = 1; pc_if.player_hit = 1; pc_if.tick = 1;
    @(negedge clk);
    pc_if.player_hit = 0; pc_if.tick = 0;
    chk("hit_lives", pc_if.lives, 2);
    chk("hit_dead", pc_if.player_alive, 0);
    chk("hit_bact", pc_if.bullet_active, 0);
    chk("hit_nomove", pc_if.player_x, 309);
    ticks(59);
    chk("dead_59", pc_if.player_alive, 0);
    chk("dead_x", pc_if.player_x, 309);
    ticks(1);
    pc_if.left = 0;
    chk("respawn", pc_if.player_alive, 1);
    chk("respawn_x", pc_if.player_x, 307);

    // Remaining lives to game over.
    phit();
    chk("hit2_lives", pc_if.lives, 1);
    ticks(60);
    chk("respawn2", pc_if.player_alive, 1);
    phit();
    chk("go_lives", pc_if.lives, 0);
    chk("go_flag", pc_if.game_over, 1);
    chk("go_alive", pc_if.player_alive, 0);
    pc_if.right = 1;
    shoot_pulse();
    ticks(5);
    phit();
    pc_if.right = 0;
    chk("go_frz_x", pc_if.player_x, 307);
    chk("go_frz_lives", pc_if.lives, 0);
    chk("go_frz_bact", pc_if.bullet_active, 0);
    chk("go_frz_flag", pc_if.game_over, 1);
    soft_restart();
    chk("restart_lives", pc_if.lives, 3);
    chk("restart_alive", pc_if.player_alive, 1);
    chk("restart_go", pc_if.game_over, 0);

    // Async reset mid-flight, between clock edges.
    shoot_pulse();
    ticks(3);
    chk("flight_y", pc_if.bullet_y, 424);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bact", pc_if.bullet_active, 0);
    chk("arst_by", pc_if.bullet_y, 0);
    chk("arst_bx", pc_if.bullet_x, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-DEAD.
    pc_if.right = 1;
    ticks(5);
    pc_if.right = 0;
    chk("pre_dead_x", pc_if.player_x, 317);
    phit();
    ticks(10);
    chk("mid_dead", pc_if.player_alive, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alive", pc_if.player_alive, 1);
    chk("arst_lives", pc_if.lives, 3);
    chk("arst_x", pc_if.player_x, 307);
    chk("arst_go", pc_if.game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
